fetch_redirect: RTL
===================

FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 SHALL have ports: clk in 1 system clock; CLR_n in 1 reset, asynchronous, active-low.
REQ-002 SHALL have ports: IR_in in 32 fetched instruction; PC_in in 32 fetch word index +1; bubble_in in 1 IF redirect-in-progress flag.
REQ-003 SHALL have ports: rs_data in 32, rt_data in 32 register operands of the ID instruction; rs_ready in 1 operands valid; stall_in in 1 external hazard stall.
REQ-004 SHALL have ports: Jaddr out 32; PC_branch out 32; J, JAL, JR, Branch out 1 each; PC_EN out 1 (redirect/enable drive to IF).
REQ-005 SHALL have ports: IR_id out 32, PC_id out 32, valid_id out 1 (IF/ID latch); halted out 1; redirect_cnt out 16; stall_cnt out 16.

Function
REQ-006 SHALL hold IF/ID latch {IR_id, PC_id, valid_id}; on each edge with PC_EN=1, load {IR_in, PC_in, 1}, unless squash applies.
REQ-007 SHALL squash: on an edge where any redirect output is 1, load {0, 0, 0} (bubble) instead of IF's sequential instruction.
REQ-008 SHALL hold the latch unchanged on any edge with PC_EN=0.
REQ-009 SHALL decode only when valid_id=1: J opcode 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, JR opcode 0x00 funct 0x08, HALT = 0x0000000C.
REQ-010 SHALL drive Jaddr = {6'b0, IR_id[25:0]} for J/JAL; Jaddr = {2'b0, rs_data[31:2]} for JR; else 0.
REQ-011 SHALL drive PC_branch = PC_id + sign-extended IR_id[15:0], modulo 2^32 (wrap allowed, no flag).
REQ-012 SHALL assert Branch for BEQ with rs_data==rt_data or BNE with rs_data!=rt_data; at most one of J/JAL/JR/Branch high.
REQ-013 SHALL implement FSM RUN, WAIT, HALT.
REQ-014 RUN: JR/BEQ/BNE in ID with rs_ready=0 -> WAIT; HALT instruction in ID -> HALT; else stay.
REQ-015 WAIT: rs_ready=1 -> RUN (redirect evaluated in that same cycle); else stay.
REQ-016 HALT: absorbing until CLR_n; halted=1.
REQ-017 SHALL drive PC_EN = 0 when state=HALT, stall_in=1, or state=WAIT / entering WAIT; else 1. Priority: HALT > stall_in > rs wait > redirect.
REQ-018 SHALL force J/JAL/JR/Branch=0 whenever PC_EN=0; stalled redirect re-evaluated each cycle.
REQ-019 Redirect latency: redirect outputs combinational from latch; IF loads target at the same edge; target instruction in ID one cycle later (one bubble per taken redirect).
REQ-020 SHALL increment redirect_cnt per cycle with a redirect output high; stall_cnt per cycle with PC_EN=0 outside HALT; both saturate at 0xFFFF.
REQ-021 bubble_in=1 with valid_id=0 SHALL be legal and cause no action; bubble_in=1 with no local redirect SHALL not alter the latch.

Reset
REQ-022 CLR_n=0 SHALL asynchronously set state RUN, IR_id=0, PC_id=0, valid_id=0, both counters 0, halted=0.
REQ-023 During and after reset, all redirect outputs SHALL be 0 and PC_EN=1 (empty latch); reset mid-WAIT or mid-HALT returns to RUN.
REQ-024 Reset deassertion SHALL be synchronised by top level; no local synchroniser.

Structure
REQ-025 Shared package SHALL hold opcode/funct constants, HALT encoding, FSM state enum.
REQ-026 SHALL use one combinational sub-module redirect_decode (IR_id, rs/rt, PC_id -> J/JAL/JR/Branch, Jaddr, PC_branch); FSM, latch, counters in fetch_redirect.

Verification
REQ-027 BEQ taken: IR_id=0x10220003, PC_id=0x10, rs=rt=5 -> Branch=1, PC_branch=0x13, next latch valid_id=0, redirect_cnt=1.
REQ-028 BNE not taken with rs=rt=7: IR_id=0x14220005 -> Branch=0, PC_EN=1, IR_in latched next edge.
REQ-029 JR wait: IR_id=0x03E00008, rs_ready=0 for 3 cycles then 1, rs_data=0x100 -> PC_EN=0 3 cycles, stall_cnt=3, then JR=1, Jaddr=0x40.
REQ-030 J plus stall_in: IR_id=0x08000020, stall_in=1 one cycle -> J=0, PC_EN=0, latch held; next cycle J=1, Jaddr=0x20.
REQ-031 HALT 0x0000000C in ID -> halted=1, PC_EN=0 indefinitely; CLR_n pulse mid-HALT -> halted=0, valid_id=0, PC_EN=1 immediately.
REQ-032 Wrap/saturation: PC_id=0xFFFFFFFF, offset +2 -> PC_branch=0x1; redirect_cnt preloaded 0xFFFF holds 0xFFFF on taken branch.

Source files
------------

// File: rtl/fetch_redirect_pkg.sv
// Shared opcode/funct encodings and FSM state type for the
// fetch redirect unit.
package fetch_redirect_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam logic [31:0] HALT_INSN = 32'h0000_000C;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_e;

endpackage

// File: rtl/fetch_redirect_decode.sv
// Combinational decode of the ID-stage instruction into
// jump/branch requests and their targets.
import fetch_redirect_pkg::*;

module redirect_decode (
    input  logic        valid,
    input  logic [31:0] ir,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        j,
    output logic        jal,
    output logic        jr,
    output logic        branch,
    output logic        needs_rs,
    output logic        halt_insn,
    output logic [31:0] jaddr,
    output logic [31:0] pc_branch
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       beq;
    logic       bne;
    logic       same;

    assign op   = ir[31:26];
    assign fn   = ir[5:0];
    assign same = (rs_data == rt_data);

    assign j   = valid && (op == OP_J);
    assign jal = valid && (op == OP_JAL);
    assign jr  = valid && (op == OP_SPECIAL) && (fn == FN_JR);
    assign beq = valid && (op == OP_BEQ);
    assign bne = valid && (op == OP_BNE);

    assign branch    = (beq && same) || (bne && !same);
    assign needs_rs  = jr || beq || bne;
    assign halt_insn = valid && (ir == HALT_INSN);

    assign pc_branch = pc + {{16{ir[15]}}, ir[15:0]};

    always_comb begin
        jaddr = '0;
        unique case (1'b1)
            (j || jal): jaddr = {6'b0, ir[25:0]};
            jr:         jaddr = {2'b0, rs_data[31:2]};
            default:    ;
        endcase
    end

endmodule

// File: rtl/fetch_redirect.sv
// IF/ID latch, squash/stall control and redirect FSM; the
// redirect targets come from redirect_decode.
import fetch_redirect_pkg::*;

module fetch_redirect (
    input  logic        clk,
    input  logic        CLR_n,
    input  logic [31:0] IR_in,
    input  logic [31:0] PC_in,
    input  logic        bubble_in,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rs_ready,
    input  logic        stall_in,
    output logic [31:0] Jaddr,
    output logic [31:0] PC_branch,
    output logic        J,
    output logic        JAL,
    output logic        JR,
    output logic        Branch,
    output logic        PC_EN,
    output logic [31:0] IR_id,
    output logic [31:0] PC_id,
    output logic        valid_id,
    output logic        halted,
    output logic [15:0] redirect_cnt,
    output logic [15:0] stall_cnt
);

    state_e      state;
    logic [15:0] redirect_q;
    logic [15:0] stall_q;

    logic j_raw;
    logic jal_raw;
    logic jr_raw;
    logic br_raw;
    logic needs_rs;
    logic halt_insn;
    logic rs_wait;
    logic redirect;
    logic unused_bubble;

    // IF redirects are already squashed upstream; nothing to do here.
    assign unused_bubble = bubble_in;

    redirect_decode u_dec (
        .valid     (valid_id),
        .ir        (IR_id),
        .pc        (PC_id),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .j         (j_raw),
        .jal       (jal_raw),
        .jr        (jr_raw),
        .branch    (br_raw),
        .needs_rs  (needs_rs),
        .halt_insn (halt_insn),
        .jaddr     (Jaddr),
        .pc_branch (PC_branch)
    );

    assign rs_wait = !rs_ready &&
                     ((state == ST_WAIT) ||
                      (state == ST_RUN && needs_rs));

    assign PC_EN = (state != ST_HALT) && !stall_in && !rs_wait;

    assign J        = PC_EN && j_raw;
    assign JAL      = PC_EN && jal_raw;
    assign JR       = PC_EN && jr_raw;
    assign Branch   = PC_EN && br_raw;
    assign redirect = J || JAL || JR || Branch;

    assign halted       = (state == ST_HALT);
    assign redirect_cnt = redirect_q;
    assign stall_cnt    = stall_q;

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= ST_RUN;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (needs_rs && !rs_ready)
                        state <= ST_WAIT;
                    else if (halt_insn)
                        state <= ST_HALT;
                end
                ST_WAIT: begin
                    if (rs_ready)
                        state <= ST_RUN;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            IR_id    <= '0;
            PC_id    <= '0;
            valid_id <= 1'b0;
        end else if (PC_EN) begin
            if (redirect) begin
                IR_id    <= '0;
                PC_id    <= '0;
                valid_id <= 1'b0;
            end else begin
                IR_id    <= IR_in;
                PC_id    <= PC_in;
                valid_id <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            redirect_q <= '0;
            stall_q    <= '0;
        end else begin
            if (redirect && redirect_q != CNT_MAX)
                redirect_q <= redirect_q + 16'd1;
            if (!PC_EN && state != ST_HALT && stall_q != CNT_MAX)
                stall_q <= stall_q + 16'd1;
        end
    end

endmodule
